seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Recovers the 4-digit value of a multiplexed, active-low 7-segment display; a digit latches after STABLE_CYCLES identical samples.
// Latency: latch on the STABLE_CYCLES-th identical sample edge, frame_valid one cycle after the 4th slot latch; no backpressure.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        frame_err
);

    typedef enum logic [1:0] {SEARCH, SETTLE, HELD} state_t;

    localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [3:0]  r_an;
    logic [7:0]  r_seg;
    logic        w_load;
    logic        w_latch;
    logic [3:0]  w_an_low;
    logic        w_an_vld;
    logic        w_same;
    logic [3:0]  w_dec_val;
    logic        w_dec_err;
    logic [1:0]  w_slot;
    logic [3:0]  w_slot_oh;
    logic [3:0]  r_cap;
    logic [3:0]  r_err;
    logic [3:0]  w_cap_base;
    logic [3:0]  w_err_base;
    logic        w_frame_done;
    logic [15:0] r_digits;
    logic [3:0]  r_dp;
    logic        r_fv;
    logic        r_ferr;

    assign w_an_low = ~an;
    assign w_an_vld = (w_an_low != 4'd0) && ((w_an_low & (w_an_low - 4'd1)) == 4'd0);
    assign w_same   = (an == r_an) && (seg == r_seg);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_an_vld) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = 8'd1;
                    w_load      = 1'b1;
                end
            end
            SETTLE: begin
                if (w_same) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (r_cnt + 8'd1 == LP_STABLE) begin
                        w_latch     = 1'b1;
                        w_state_nxt = HELD;
                    end
                end else if (w_an_vld) begin
                    w_cnt_nxt = 8'd1;
                    w_load    = 1'b1;
                end else begin
                    w_state_nxt = SEARCH;
                    w_cnt_nxt   = 8'd0;
                end
            end
            HELD: begin
                if (!w_same) begin
                    if (w_an_vld) begin
                        w_state_nxt = SETTLE;
                        w_cnt_nxt   = 8'd1;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = SEARCH;
                        w_cnt_nxt   = 8'd0;
                    end
                end
            end
            default: begin
                w_state_nxt = SEARCH;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // The latch always uses the stored sample, which equals the current one on a latch edge.
    always_comb begin
        w_dec_err = 1'b0;
        w_dec_val = 4'hF;
        case (r_seg[7:1])
            7'b0000001: w_dec_val = 4'd0;
            7'b1001111: w_dec_val = 4'd1;
            7'b0010010: w_dec_val = 4'd2;
            7'b0000110: w_dec_val = 4'd3;
            7'b1001100: w_dec_val = 4'd4;
            7'b0100100: w_dec_val = 4'd5;
            7'b0100000: w_dec_val = 4'd6;
            7'b0001111: w_dec_val = 4'd7;
            7'b0000000: w_dec_val = 4'd8;
            7'b0000100: w_dec_val = 4'd9;
            default:    w_dec_err = 1'b1;
        endcase
    end

    always_comb begin
        w_slot = 2'd0;
        case (r_an)
            4'b1110: w_slot = 2'd0;
            4'b1101: w_slot = 2'd1;
            4'b1011: w_slot = 2'd2;
            4'b0111: w_slot = 2'd3;
            default: w_slot = 2'd0;
        endcase
    end

    assign w_slot_oh    = ~r_an;
    assign w_frame_done = (r_cap == 4'hF);
    // A latch on the frame-completion edge starts the next frame instead of being lost.
    assign w_cap_base   = w_frame_done ? 4'h0 : r_cap;
    assign w_err_base   = w_frame_done ? 4'h0 : r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= SEARCH;
            r_cnt    <= 8'd0;
            r_an     <= 4'h0;
            r_seg    <= 8'h00;
            r_cap    <= 4'h0;
            r_err    <= 4'h0;
            r_digits <= 16'h0000;
            r_dp     <= 4'h0;
            r_fv     <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_an  <= an;
                r_seg <= seg;
            end
            r_fv <= w_frame_done;
            if (w_frame_done) begin
                r_ferr <= |r_err;
            end
            r_cap <= w_cap_base | (w_latch ? w_slot_oh : 4'h0);
            r_err <= w_err_base | ((w_latch && w_dec_err) ? w_slot_oh : 4'h0);
            if (w_latch) begin
                r_digits[w_slot*4 +: 4] <= w_dec_val;
                r_dp[w_slot]            <= ~r_seg[0];
            end
        end
    end

    assign digits      = r_digits;
    assign dp          = r_dp;
    assign frame_valid = r_fv;
    assign frame_err   = r_ferr;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with STABLE_CYCLES=4; inputs change and outputs are sampled on the falling edge.
module tb_seg_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        frame_err;

    int n_checks = 0;
    int n_fails  = 0;
    int fv_cnt   = 0;
    logic        last_err = 1'b0;
    logic [15:0] last_digits = 16'h0;
    int fv_base;

    localparam logic [7:0] S_1    = 8'b10011111;
    localparam logic [7:0] S_2    = 8'b00100101;
    localparam logic [7:0] S_3    = 8'b00001101;
    localparam logic [7:0] S_4    = 8'b10011001;
    localparam logic [7:0] S_5    = 8'b01001001;
    localparam logic [7:0] S_6    = 8'b01000001;
    localparam logic [7:0] S_7    = 8'b00011111;
    localparam logic [7:0] S_8    = 8'b00000001;
    localparam logic [7:0] S_0    = 8'b00000011;
    localparam logic [7:0] S_0DP  = 8'b00000010;
    localparam logic [7:0] S_BAD  = 8'b11111111;

    seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .digits      (digits),
        .dp          (dp),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt      <= fv_cnt + 1;
            last_err    <= frame_err;
            last_digits <= digits;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold (a, s) for n rising edges; called and returns on a falling edge.
    task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);

        rst_n = 1'b1;
        drive(4'hF, 8'hFF, 2);

        fv_base = fv_cnt;
        drive(4'b1110, S_1, 8);
        drive(4'b1101, S_2, 8);
        drive(4'b1011, S_3, 8);
        drive(4'b0111, S_4, 8);
        drive(4'hF, 8'hFF, 3);
        check("scan_fv_count", 32'(fv_cnt - fv_base), 32'd1);
        check("scan_digits", 32'(digits), 32'h4321);
        check("scan_dp", 32'(dp), 32'h0);
        check("scan_ferr", 32'(last_err), 32'h0);
        check("scan_fv_digits", 32'(last_digits), 32'h4321);
        check("scan_fv_low", 32'(frame_valid), 32'h0);

        fv_base = fv_cnt;
        drive(4'b1110, S_0, 3);
        drive(4'hF, 8'hFF, 4);
        check("short_hold_digits", 32'(digits), 32'h4321);

        drive(4'b1100, S_8, 10);
        drive(4'b1111, S_8, 10);
        check("bad_an_digits", 32'(digits), 32'h4321);
        check("bad_an_fv", 32'(fv_cnt - fv_base), 32'd0);

        fv_base = fv_cnt;
        drive(4'b1110, S_8, 6);
        drive(4'b1101, S_7, 6);
        drive(4'b1011, S_BAD, 6);
        drive(4'b0111, S_6, 6);
        drive(4'hF, 8'hFF, 3);
        check("err_fv_count", 32'(fv_cnt - fv_base), 32'd1);
        check("err_digits", 32'(digits), 32'h6F78);
        check("err_ferr", 32'(last_err), 32'h1);
        check("err_dp", 32'(dp), 32'h0);

        fv_base = fv_cnt;
        drive(4'b1110, S_0DP, 6);
        drive(4'hF, 8'hFF, 2);
        check("dp_digits", 32'(digits), 32'h6F70);
        check("dp_dp", 32'(dp), 32'h1);

        drive(4'b1101, S_2, 2);
        drive(4'hF, 8'hFF, 4);
        check("glitch_digits", 32'(digits), 32'h6F70);
        check("glitch_dp", 32'(dp), 32'h1);

        drive(4'b1110, S_5, 6);
        drive(4'b1101, S_6, 6);
        drive(4'b1011, S_7, 6);
        drive(4'hF, 8'hFF, 2);
        check("partial_digits", 32'(digits), 32'h6765);
        check("partial_fv", 32'(fv_cnt - fv_base), 32'd0);

        rst_n = 1'b0;
        drive(4'hF, 8'hFF, 2);
        check("midframe_rst_digits", 32'(digits), 32'h0);
        rst_n = 1'b1;
        drive(4'hF, 8'hFF, 2);

        fv_base = fv_cnt;
        drive(4'b1110, S_5, 8);
        drive(4'b1101, S_6, 8);
        drive(4'b1011, S_7, 8);
        drive(4'b0111, S_8, 8);
        drive(4'hF, 8'hFF, 4);
        check("post_rst_fv_count", 32'(fv_cnt - fv_base), 32'd1);
        check("post_rst_digits", 32'(digits), 32'h8765);
        check("post_rst_ferr", 32'(last_err), 32'h0);
        check("post_rst_dp", 32'(dp), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
